mult_acc_stage: RTL

- Sequential stage directly downstream of the 4x4 array multiplier (8-bit product output).
- Consumes one 8-bit product per valid/ready beat and accumulates VEC_LEN products into a dot-product sum.
- Presents the sum on a valid/ready output port.
- Product generation stays combinational upstream; this block adds the registers, the beat counter and the flow control.

---
 rtl/mult_acc_if.sv | 34 +++
 rtl/mult_acc_stage.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mult_acc_if.sv
// Product-in / sum-out handshake bundle for mult_acc_stage.
// The master side drives products and out_ready; the slave side is the accumulator stage.
interface mult_acc_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16
);
    logic [PROD_W-1:0] prod_in;
    logic              in_valid;
    logic              in_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              out_valid;
    logic              out_ready;
    logic              acc_ovf;

    modport master (
        output prod_in,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  acc_out,
        input  out_valid,
        input  acc_ovf
    );

    modport slave (
        input  prod_in,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output acc_out,
        output out_valid,
        output acc_ovf
    );
endinterface

// File: rtl/mult_acc_stage.sv
// Accumulates VEC_LEN unsigned products into one dot-product sum, valid/ready on both sides.
// Define MULT_ACC_SAT_EN to saturate the running sum instead of wrapping modulo 2^ACC_W.
module mult_acc_stage #(
    parameter int PROD_W  = 8,
    parameter int ACC_W   = 16,
    parameter int VEC_LEN = 4,
    parameter int CNT_W   = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clr,
    mult_acc_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VEC_LEN - 1);

    state_t             r_state,     w_state_nxt;
    logic [ACC_W-1:0]   r_acc,       w_acc_nxt;
    logic [CNT_W-1:0]   r_cnt,       w_cnt_nxt;
    logic               r_ovf_int,   w_ovf_int_nxt;
    logic [ACC_W-1:0]   r_acc_out,   w_acc_out_nxt;
    logic               r_out_valid, w_out_valid_nxt;
    logic               r_acc_ovf,   w_acc_ovf_nxt;

    logic               w_in_ready;
    logic               w_accept;
    logic [ACC_W-1:0]   w_base_acc;
    logic [CNT_W-1:0]   w_base_cnt;
    logic               w_base_ovf;
    logic [ACC_W:0]     w_sum;

    // Returns {carry, stored value}; the carry is kept even when saturating.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [PROD_W-1:0] p);
        logic [ACC_W:0] s;
        s = {1'b0, a} + (ACC_W+1)'(p);
`ifdef MULT_ACC_SAT_EN
        if (s[ACC_W]) s[ACC_W-1:0] = '1;
`endif
        return s;
    endfunction

    assign w_in_ready = (r_state != HOLD) && !clr;
    assign w_accept   = bus.in_valid && w_in_ready;

    // IDLE starts a fresh vector, so it folds into the ACCUM path with a zero base.
    always_comb begin
        w_base_acc = (r_state == IDLE) ? '0   : r_acc;
        w_base_cnt = (r_state == IDLE) ? '0   : r_cnt;
        w_base_ovf = (r_state == IDLE) ? 1'b0 : r_ovf_int;
        w_sum      = acc_add(w_base_acc, bus.prod_in);
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_ovf_int_nxt   = r_ovf_int;
        w_acc_out_nxt   = r_acc_out;
        w_out_valid_nxt = r_out_valid;
        w_acc_ovf_nxt   = r_acc_ovf;
        if (clr) begin
            w_state_nxt     = IDLE;
            w_acc_nxt       = '0;
            w_cnt_nxt       = '0;
            w_ovf_int_nxt   = 1'b0;
            w_out_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_accept) begin
                        if (w_base_cnt == LAST_BEAT) begin
                            w_acc_out_nxt   = w_sum[ACC_W-1:0];
                            w_acc_ovf_nxt   = w_base_ovf | w_sum[ACC_W];
                            w_out_valid_nxt = 1'b1;
                            w_acc_nxt       = '0;
                            w_cnt_nxt       = '0;
                            w_ovf_int_nxt   = 1'b0;
                            w_state_nxt     = HOLD;
                        end else begin
                            w_acc_nxt     = w_sum[ACC_W-1:0];
                            w_cnt_nxt     = w_base_cnt + 1'b1;
                            w_ovf_int_nxt = w_base_ovf | w_sum[ACC_W];
                            w_state_nxt   = ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        w_out_valid_nxt = 1'b0;
                        w_state_nxt     = IDLE;
                    end
                end
                default: begin
                    w_state_nxt     = IDLE;
                    w_out_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf_int   <= 1'b0;
            r_acc_out   <= '0;
            r_out_valid <= 1'b0;
            r_acc_ovf   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ovf_int   <= w_ovf_int_nxt;
            r_acc_out   <= w_acc_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_acc_ovf   <= w_acc_ovf_nxt;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.acc_out   = r_acc_out;
    assign bus.out_valid = r_out_valid;
    assign bus.acc_ovf   = r_acc_ovf;
endmodule
